// File: rtl/if_fetch_unit.sv
// if_fetch_unit: P5 MIPS instruction fetch stage -- PC register, next-PC select and IF/ID register.
// Optional macro IF_ADDR_CHECK_EN flags misaligned or out-of-range fetches through id_exc.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid,
    output logic [31:0] fetch_count,
    output logic        id_exc
);

    logic [31:0] r_pc;
    logic [31:0] r_idInstr;
    logic [31:0] r_idPc;
    logic [31:0] r_idPc8;
    logic        r_idValid;
    logic [31:0] r_fetchCount;
    logic        r_idExc;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_pcPlus8;
    logic [31:0] w_nextPc;
    logic        w_addrBad;

    assign w_pcPlus4 = r_pc + 32'd4;
    assign w_pcPlus8 = r_pc + 32'd8;
    assign w_nextPc  = redirect ? redirect_target : w_pcPlus4;

`ifdef IF_ADDR_CHECK_EN
    // 33-bit limit so a text segment ending at the top of the address space cannot wrap.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

    assign w_addrBad = (r_pc[1:0] != 2'b00) || (r_pc < RESET_PC) || ({1'b0, r_pc} >= PC_LIMIT);
`else
    assign w_addrBad = 1'b0;
`endif

    // Stall freezes both PC and IF/ID, so a redirect or flush seen during a stall is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_idInstr    <= '0;
            r_idPc       <= '0;
            r_idPc8      <= '0;
            r_idValid    <= 1'b0;
            r_fetchCount <= '0;
            r_idExc      <= 1'b0;
        end else if (!stall) begin
            r_pc <= w_nextPc;
            if (flush) begin
                r_idInstr <= '0;
                r_idValid <= 1'b0;
                r_idExc   <= 1'b0;
            end else begin
                r_idInstr    <= w_addrBad ? 32'd0 : im_instr;
                r_idPc       <= r_pc;
                r_idPc8      <= w_pcPlus8;
                r_idValid    <= 1'b1;
                r_idExc      <= w_addrBad;
                r_fetchCount <= r_fetchCount + 32'd1;
            end
        end
    end

    assign im_pc       = r_pc;
    assign id_instr    = r_idInstr;
    assign id_pc       = r_idPc;
    assign id_pc8      = r_idPc8;
    assign id_valid    = r_idValid;
    assign fetch_count = r_fetchCount;
    assign id_exc      = r_idExc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven, hand-sequenced and randomized checks of if_fetch_unit.
// Honours IF_ADDR_CHECK_EN the same way the design does.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 1024;
`ifdef IF_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect;
    logic [31:0] redirect_target;
    logic [31:0] im_pc, im_instr, id_instr, id_pc, id_pc8, fetch_count;
    logic        id_valid, id_exc;

    logic [31:0] mem [0:IM_WORDS-1];

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] mPc, mInstr, mIdPc, mIdPc8, mCount;
    logic        mValid, mExc;

    typedef struct {
        logic        rst, stl, fls, rdr;
        logic [31:0] tgt;
        logic [31:0] expPc, expIdPc, expInstr, expPc8;
        logic        expValid;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs [18];

    if_fetch_unit #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .im_pc           (im_pc),
        .im_instr        (im_instr),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc8          (id_pc8),
        .id_valid        (id_valid),
        .fetch_count     (fetch_count),
        .id_exc          (id_exc)
    );

    always #5 clk = ~clk;

    assign im_instr = mem[im_pc[11:2]];

    function automatic logic [31:0] memWord(int i);
        case (i)
            0:       return 32'h2401_0001;
            1:       return 32'h2402_0002;
            2:       return 32'h0022_1821;
            default: return 32'h3C00_0000 + (32'(i) << 12) + 32'(i);
        endcase
    endfunction

    // Legal fetch window is [RESET_PC, RESET_PC + 4*IM_WORDS), word aligned.
    function automatic logic addrBad(logic [31:0] pc);
        longint unsigned p;
        p = 64'(pc);
        return CHECK_EN && ((p % 4 != 0) || (p < 64'(RESET_PC)) || (p >= 64'(RESET_PC) + 4 * IM_WORDS));
    endfunction

    function automatic vec_t mk(logic r, logic s, logic f, logic rd, logic [31:0] tgt,
                                logic [31:0] pc, logic [31:0] idPc, logic [31:0] instr,
                                logic [31:0] pc8, logic v, logic [31:0] cnt);
        vec_t t;
        t.rst = r; t.stl = s; t.fls = f; t.rdr = rd; t.tgt = tgt;
        t.expPc = pc; t.expIdPc = idPc; t.expInstr = instr; t.expPc8 = pc8;
        t.expValid = v; t.expCount = cnt;
        return t;
    endfunction

    task automatic modelStep(input logic r, input logic s, input logic f, input logic rd,
                             input logic [31:0] tgt);
        logic bad;
        if (r) begin
            mPc = RESET_PC; mInstr = 0; mIdPc = 0; mIdPc8 = 0; mValid = 0; mCount = 0; mExc = 0;
        end else if (!s) begin
            if (f) begin
                mInstr = 0; mValid = 0; mExc = 0;
            end else begin
                bad    = addrBad(mPc);
                mInstr = bad ? 32'd0 : mem[mPc[11:2]];
                mIdPc  = mPc;
                mIdPc8 = mPc + 32'd8;
                mValid = 1'b1;
                mExc   = bad;
                mCount = mCount + 32'd1;
            end
            mPc = rd ? tgt : mPc + 32'd4;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic f, input logic rd,
                                 input logic [31:0] tgt);
        reset = r; stall = s; flush = f; redirect = rd; redirect_target = tgt;
        modelStep(r, s, f, rd, tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".im_pc"},       im_pc,              mPc);
        checkField({tag, ".id_instr"},    id_instr,           mInstr);
        checkField({tag, ".id_pc"},       id_pc,              mIdPc);
        checkField({tag, ".id_pc8"},      id_pc8,             mIdPc8);
        checkField({tag, ".id_valid"},    {31'd0, id_valid},  {31'd0, mValid});
        checkField({tag, ".fetch_count"}, fetch_count,        mCount);
        checkField({tag, ".id_exc"},      {31'd0, id_exc},    {31'd0, mExc});
    endtask

    task automatic checkVector(input int k);
        string tag;
        tag = $sformatf("vec%0d", k);
        checkField({tag, ".im_pc"},       im_pc,             vecs[k].expPc);
        checkField({tag, ".id_instr"},    id_instr,          vecs[k].expInstr);
        checkField({tag, ".id_pc"},       id_pc,             vecs[k].expIdPc);
        checkField({tag, ".id_pc8"},      id_pc8,            vecs[k].expPc8);
        checkField({tag, ".id_valid"},    {31'd0, id_valid}, {31'd0, vecs[k].expValid});
        checkField({tag, ".fetch_count"}, fetch_count,       vecs[k].expCount);
        checkField({tag, ".id_exc"},      {31'd0, id_exc},   32'd0);
    endtask

    initial begin
        logic        rr, rs, rf, rd;
        logic [31:0] rt;

        for (int i = 0; i < IM_WORDS; i++) mem[i] = memWord(i);
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = '0;
        mPc = RESET_PC; mInstr = 0; mIdPc = 0; mIdPc8 = 0; mValid = 0; mCount = 0; mExc = 0;

        //               r  s  f  rd target         pc            id_pc         id_instr       id_pc8        v  count
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,      32'h3000, 32'h0,    32'h0,        32'h0,    0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,      32'h3004, 32'h3000, 32'h24010001, 32'h3008, 1, 1);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,      32'h3008, 32'h3004, 32'h24020002, 32'h300C, 1, 2);
        vecs[3]  = mk(0, 1, 0, 0, 32'h0,      32'h3008, 32'h3004, 32'h24020002, 32'h300C, 1, 2);
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,      32'h3008, 32'h3004, 32'h24020002, 32'h300C, 1, 2);
        vecs[5]  = mk(0, 0, 0, 0, 32'h0,      32'h300C, 32'h3008, 32'h00221821, 32'h3010, 1, 3);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,      32'h3010, 32'h300C, memWord(3),   32'h3014, 1, 4);
        vecs[7]  = mk(0, 0, 0, 1, 32'h3040,   32'h3040, 32'h3010, memWord(4),   32'h3018, 1, 5);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,      32'h3044, 32'h3040, memWord(16),  32'h3048, 1, 6);
        vecs[9]  = mk(0, 0, 0, 1, 32'h3020,   32'h3020, 32'h3044, memWord(17),  32'h304C, 1, 7);
        vecs[10] = mk(0, 0, 1, 0, 32'h0,      32'h3024, 32'h3044, 32'h0,        32'h304C, 0, 7);
        vecs[11] = mk(0, 1, 1, 0, 32'h0,      32'h3024, 32'h3044, 32'h0,        32'h304C, 0, 7);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,      32'h3028, 32'h3024, memWord(9),   32'h302C, 1, 8);
        vecs[13] = mk(0, 1, 0, 1, 32'h3100,   32'h3028, 32'h3024, memWord(9),   32'h302C, 1, 8);
        vecs[14] = mk(0, 0, 0, 1, 32'h3100,   32'h3100, 32'h3028, memWord(10),  32'h3030, 1, 9);
        vecs[15] = mk(0, 1, 0, 0, 32'h0,      32'h3100, 32'h3028, memWord(10),  32'h3030, 1, 9);
        vecs[16] = mk(1, 1, 0, 0, 32'h0,      32'h3000, 32'h0,    32'h0,        32'h0,    0, 0);
        vecs[17] = mk(1, 1, 1, 1, 32'h3200,   32'h3000, 32'h0,    32'h0,        32'h0,    0, 0);

        for (int k = 0; k < 18; k++) begin
            applyStimulus(vecs[k].rst, vecs[k].stl, vecs[k].fls, vecs[k].rdr, vecs[k].tgt);
            checkVector(k);
        end

        // Misaligned and out-of-range fetches reached through redirect.
        applyStimulus(1, 0, 0, 0, 32'h0);
        checkOutput("exc.reset");
        applyStimulus(0, 0, 0, 1, 32'h3002);
        checkOutput("exc.toMis");
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("exc.mis");
        checkField("exc.misFlag",  {31'd0, id_exc}, CHECK_EN ? 32'd1 : 32'd0);
        checkField("exc.misInstr", id_instr,        CHECK_EN ? 32'd0 : memWord(0));
        checkField("exc.misPc",    id_pc,           32'h3002);
        applyStimulus(0, 0, 0, 1, 32'h4000);
        checkOutput("exc.toHigh");
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("exc.high");
        checkField("exc.highFlag", {31'd0, id_exc}, CHECK_EN ? 32'd1 : 32'd0);
        checkField("exc.highPc",   id_pc,           32'h4000);
        applyStimulus(0, 1, 0, 0, 32'h0);
        checkField("exc.stallHold", {31'd0, id_exc}, CHECK_EN ? 32'd1 : 32'd0);
        applyStimulus(0, 0, 1, 0, 32'h0);
        checkOutput("exc.flush");
        checkField("exc.flushClr", {31'd0, id_exc}, 32'd0);

        // PC+4 wraps past the top of the address space.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFC);
        checkOutput("wrap.toTop");
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkField("wrap.pc", im_pc, 32'h0);
        checkOutput("wrap.top");
        applyStimulus(0, 0, 0, 0, 32'h0);
        checkOutput("wrap.zero");

        applyStimulus(1, 0, 0, 0, 32'h0);
        for (int c = 0; c < 400; c++) begin
            rr = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 25);
            rf = ($urandom_range(0, 99) < 15);
            rd = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 9) == 0) rt = $urandom;
            else rt = RESET_PC + 32'($urandom_range(0, IM_WORDS - 1)) * 32'd4;
            applyStimulus(rr, rs, rf, rd, rt);
            checkOutput($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
